// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a registered, time-multiplexed digit scanner.
// Optional leading-zero blanking of the scanned display: define LEADING_ZERO_BLANK_EN.
module bcd_scan_counter #(
    parameter int CNT_DIV  = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up_dn,
    input  logic                clr,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                wrap,
    output logic [3:0]          digit_bcd,
    output logic [DIGITS-1:0]   digit_sel
);

    localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]          bcd_q, bcd_d;

    logic                tick;
    logic                scan_last;
    logic [4*DIGITS-1:0] step_val;
    logic                step_wrap;
    logic                ripple;
    logic [3:0]          cur;

    assign tick      = en && (presc_q == PRESC_MAX);
    assign scan_last = (scan_cnt_q == SCAN_MAX);

    // Decimal step with ripple carry/borrow; the carry out of the top digit is the wrap.
    always_comb begin
        step_val = '0;
        ripple   = 1'b1;
        cur      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            cur = count_q[4*i +: 4];
            if (!ripple) begin
                step_val[4*i +: 4] = cur;
            end else if (up_dn) begin
                if (cur == 4'd9) begin
                    step_val[4*i +: 4] = 4'd0;
                end else begin
                    step_val[4*i +: 4] = cur + 4'd1;
                    ripple             = 1'b0;
                end
            end else begin
                if (cur == 4'd0) begin
                    step_val[4*i +: 4] = 4'd9;
                end else begin
                    step_val[4*i +: 4] = cur - 4'd1;
                    ripple             = 1'b0;
                end
            end
        end
        step_wrap = ripple;
    end

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            presc_d = '0;
            count_d = '0;
        end else if (tick) begin
            presc_d = '0;
            count_d = step_val;
            wrap_d  = step_wrap;
        end else if (en) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_comb begin
        scan_cnt_d = scan_last ? '0 : scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        if (scan_last) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i]: digit i and every more significant digit are zero.
    logic [DIGITS-1:0] zero_from;
    logic              zero_run;

    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (count_q[4*i +: 4] == 4'd0);
            zero_from[i] = zero_run;
        end
    end
`endif

    always_comb begin
        sel_d = '1;
        bcd_d = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
`ifdef LEADING_ZERO_BLANK_EN
                if ((i == 0) || !zero_from[i]) begin
                    sel_d[i] = 1'b0;
                    bcd_d    = count_q[4*i +: 4];
                end
`else
                sel_d[i] = 1'b0;
                bcd_d    = count_q[4*i +: 4];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            sel_q      <= '1;
            bcd_q      <= 4'd0;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            bcd_q      <= bcd_d;
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign digit_sel = sel_q;
    assign digit_bcd = bcd_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4, CNT_DIV=4, SCAN_DIV=2).
// Blanking expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_scan_counter;

    localparam int DIGITS   = 4;
    localparam int CNT_DIV  = 4;
    localparam int SCAN_DIV = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] SEL_LOW = 16'hFFFE;
`else
    localparam logic [15:0] SEL_LOW = 16'h7BDE;
`endif
    localparam logic [15:0] SEL_ALL = 16'h7BDE;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [3:0]  digit_bcd;
    logic [3:0]  digit_sel;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    bcd_scan_counter #(
        .CNT_DIV  (CNT_DIV),
        .SCAN_DIV (SCAN_DIV),
        .DIGITS   (DIGITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .clr       (clr),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .digit_bcd (digit_bcd),
        .digit_sel (digit_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Align to the first cycle of slot 0, then check two cycles of every slot.
    task automatic check_scan(input string tag, input logic [15:0] sel_tab, input logic [15:0] bcd_tab);
        logic [3:0] prev;
        logic [7:0] e;
        int         n;
        prev = digit_sel;
        n    = 0;
        @(negedge clk);
        while (!(digit_sel == 4'b1110 && prev != 4'b1110) && n < 20) begin
            prev = digit_sel;
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_sync"}, 32'(n < 20), 32'd1);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({sel_tab[4*(k/2) +: 4], bcd_tab[4*(k/2) +: 4]});
        end
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s_sel%0d", tag, k), 32'(digit_sel), 32'(e[7:4]));
            check_eq($sformatf("%s_bcd%0d", tag, k), 32'(digit_bcd), 32'(e[3:0]));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] prev_sel;
        int         changes;

        rst_n = 1'b0;
        en    = 1'b0;
        up_dn = 1'b1;
        clr   = 1'b0;
        wait_clks(2);
        check_eq("rst_count", 32'(count_bcd), 32'h0);
        check_eq("rst_sel", 32'(digit_sel), 32'hF);
        check_eq("rst_bcd", 32'(digit_bcd), 32'h0);
        check_eq("rst_wrap", 32'(wrap), 32'h0);

        rst_n = 1'b1;
        wait_clks(1);
        check_eq("first_sel", 32'(digit_sel), 32'hE);
        check_eq("first_bcd", 32'(digit_bcd), 32'h0);

        // Up count with decimal carry.
        en = 1'b1;
        wait_clks(36);
        check_eq("up_0009", 32'(count_bcd), 32'h0009);
        wait_clks(3);
        check_eq("up_0009_hold", 32'(count_bcd), 32'h0009);
        wait_clks(1);
        check_eq("up_0010", 32'(count_bcd), 32'h0010);
        wait_clks(4);
        check_eq("up_0011", 32'(count_bcd), 32'h0011);
        check_eq("up_no_wrap", 32'(wrap), 32'h0);

        // Freeze: count and prescaler hold, scanner keeps moving.
        en       = 1'b0;
        prev_sel = digit_sel;
        changes  = 0;
        for (int k = 0; k < 20; k++) begin
            wait_clks(1);
            if (digit_sel != prev_sel) changes++;
            prev_sel = digit_sel;
        end
        check_eq("freeze_count", 32'(count_bcd), 32'h0011);
        check_eq("freeze_scan_moves", 32'(changes), 32'd10);
        en = 1'b1;
        wait_clks(3);
        check_eq("resume_hold", 32'(count_bcd), 32'h0011);
        wait_clks(1);
        check_eq("resume_0012", 32'(count_bcd), 32'h0012);
        wait_clks(120);
        check_eq("up_0042", 32'(count_bcd), 32'h0042);

        // clr coincident with a tick.
        wait_clks(3);
        clr = 1'b1;
        wait_clks(1);
        clr = 1'b0;
        check_eq("clr_tick_count", 32'(count_bcd), 32'h0);
        check_eq("clr_tick_wrap", 32'(wrap), 32'h0);
        wait_clks(4);
        check_eq("after_clr_0001", 32'(count_bcd), 32'h0001);

        // clr mid-prescale must restart the prescaler.
        wait_clks(2);
        clr = 1'b1;
        wait_clks(1);
        clr = 1'b0;
        check_eq("clr_mid_count", 32'(count_bcd), 32'h0);
        wait_clks(3);
        check_eq("clr_presc_reset", 32'(count_bcd), 32'h0);
        wait_clks(1);
        check_eq("clr_presc_tick", 32'(count_bcd), 32'h0001);

        // Down through zero wraps to all nines.
        up_dn = 1'b0;
        wait_clks(4);
        check_eq("down_0000", 32'(count_bcd), 32'h0000);
        check_eq("down_0000_wrap", 32'(wrap), 32'h0);
        wait_clks(3);
        check_eq("down_pre_wrap", 32'(wrap), 32'h0);
        wait_clks(1);
        check_eq("down_9999", 32'(count_bcd), 32'h9999);
        check_eq("down_wrap_pulse", 32'(wrap), 32'h1);
        wait_clks(1);
        check_eq("down_wrap_end", 32'(wrap), 32'h0);
        check_eq("down_9999_hold", 32'(count_bcd), 32'h9999);

        // Up from all nines wraps to zero.
        up_dn = 1'b1;
        wait_clks(2);
        check_eq("up_pre_wrap", 32'(wrap), 32'h0);
        check_eq("up_pre_count", 32'(count_bcd), 32'h9999);
        wait_clks(1);
        check_eq("up_wrap_count", 32'(count_bcd), 32'h0000);
        check_eq("up_wrap_pulse", 32'(wrap), 32'h1);
        wait_clks(1);
        check_eq("up_wrap_end", 32'(wrap), 32'h0);

        // Count to 1234 and check the scan order.
        wait_clks(4935);
        check_eq("up_1234", 32'(count_bcd), 32'h1234);
        en = 1'b0;
        check_scan("scan1234", SEL_ALL, 16'h1234);

        // Asynchronous reset in the middle of a clock phase.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_count", 32'(count_bcd), 32'h0);
        check_eq("midrst_sel", 32'(digit_sel), 32'hF);
        check_eq("midrst_bcd", 32'(digit_bcd), 32'h0);
        check_eq("midrst_wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(1);
        check_eq("midrst_first_sel", 32'(digit_sel), 32'hE);
        check_eq("midrst_first_bcd", 32'(digit_bcd), 32'h0);
        check_scan("scan0000", SEL_LOW, 16'h0000);

        // Fresh prescaler after reset: 28 enabled clocks give seven ticks.
        en = 1'b1;
        wait_clks(28);
        en = 1'b0;
        check_eq("up_0007", 32'(count_bcd), 32'h0007);
        check_scan("scan0007", SEL_LOW, 16'h0007);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
